// File: rtl/pam_feed_arbiter_if.sv
// PAM feed arbiter bus: source FIFO side plus modulator FIFO port.
// slave = arbiter view, master = environment (sources + modulator) view.
interface pam_feed_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_empty;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_read;
    logic               mod_read;
    logic               mod_empty;
    logic [7:0]         mod_sample;

    modport slave (
        input  req_empty, req_data, mod_read,
        output req_read, mod_empty, mod_sample
    );

    modport master (
        output req_empty, req_data, mod_read,
        input  req_read, mod_empty, mod_sample
    );
endinterface

// File: rtl/pam_feed_arbiter.sv
// PAM feed arbiter: shares the modulator FIFO port between N_REQ sources,
// one locked sample per grant. Define PAM_ARB_FIXED_PRIO_EN for fixed priority.
module pam_feed_arbiter #(
    parameter int N_REQ            = 2,
    parameter int BYTES_PER_SAMPLE = 2,
    parameter int TIMEOUT_CLKS     = 2400,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pam_feed_arbiter_if.slave     bus,
    output logic [GW-1:0]         grant,
    output logic                  grant_valid,
    output logic                  abort,
    output logic                  underrun,
    output logic [15:0]           samples_served
);
    localparam int CW = $clog2(BYTES_PER_SAMPLE + 1);
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ur_seen_q, ur_seen_d;
    logic [15:0]   served_q, served_d;
`ifndef PAM_ARB_FIXED_PRIO_EN
    logic [GW-1:0] ptr_q, ptr_d;
`endif

    logic               found;
    logic [GW-1:0]      pick;
    logic [N_REQ-1:0]   req_read_c;
    logic               mod_empty_c;
    logic [7:0]         mod_sample_c;
    logic               g_empty;
    logic [7:0]         g_data;

    assign g_empty = bus.req_empty[grant_q];
    assign g_data  = bus.req_data[8*int'(grant_q) +: 8];

    // First non-empty requester, searching upward from the start point
    always_comb begin
        int base;
        int idx;
        found = 1'b0;
        pick  = '0;
`ifdef PAM_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = int'(ptr_q) + 1;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            idx = (base + k) % N_REQ;
            if (!found && !bus.req_empty[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // Next-state logic, grant mux and event pulses
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        byte_cnt_d   = byte_cnt_q;
        timer_d      = timer_q;
        ur_seen_d    = ur_seen_q;
        served_d     = served_q;
`ifndef PAM_ARB_FIXED_PRIO_EN
        ptr_d        = ptr_q;
`endif
        abort        = 1'b0;
        underrun     = 1'b0;
        req_read_c   = '0;
        mod_empty_c  = 1'b1;
        mod_sample_c = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    byte_cnt_d = '0;
                    timer_d    = '0;
                    ur_seen_d  = 1'b0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                mod_empty_c           = g_empty;
                mod_sample_c          = g_data;
                req_read_c[grant_q]   = bus.mod_read;
                if (byte_cnt_q != '0 && g_empty && !ur_seen_q) begin
                    underrun  = 1'b1;
                    ur_seen_d = 1'b1;
                end
                // A read always beats a coincident timeout
                if (bus.mod_read) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    timer_d    = '0;
                    if (byte_cnt_q == CW'(BYTES_PER_SAMPLE - 1)) begin
                        state_d = ST_HOLD;
                    end
                end else if (timer_q == TW'(TIMEOUT_CLKS - 1)) begin
                    abort   = 1'b1;
`ifndef PAM_ARB_FIXED_PRIO_EN
                    ptr_d   = grant_q;
`endif
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // Mux stays up so the last read's byte can be captured
                mod_empty_c  = g_empty;
                mod_sample_c = g_data;
`ifndef PAM_ARB_FIXED_PRIO_EN
                ptr_d        = grant_q;
`endif
                served_d     = served_q + 16'd1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            byte_cnt_q <= '0;
            timer_q    <= '0;
            ur_seen_q  <= 1'b0;
            served_q   <= 16'd0;
`ifndef PAM_ARB_FIXED_PRIO_EN
            ptr_q      <= GW'(N_REQ - 1);
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            byte_cnt_q <= byte_cnt_d;
            timer_q    <= timer_d;
            ur_seen_q  <= ur_seen_d;
            served_q   <= served_d;
`ifndef PAM_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign bus.req_read   = req_read_c;
    assign bus.mod_empty  = mod_empty_c;
    assign bus.mod_sample = mod_sample_c;
    assign grant          = grant_q;
    assign grant_valid    = (state_q != ST_IDLE);
    assign samples_served = served_q;
endmodule

// File: tb/tb_pam_feed_arbiter.sv
// Self-checking bench for pam_feed_arbiter with a behavioural model.
// Directed scenarios: single source, round-robin, lock, timeout, underrun, reset.
module tb_pam_feed_arbiter;
    localparam int N   = 2;
    localparam int BPS = 2;
    localparam int T   = 2400;

    logic        clk;
    logic        rst;
    logic [0:0]  grant;
    logic        grant_valid;
    logic        abort;
    logic        underrun;
    logic [15:0] samples_served;

    int n_cmp = 0;
    int n_bad = 0;

    pam_feed_arbiter_if #(.N_REQ(N)) bus ();

    pam_feed_arbiter #(
        .N_REQ(N),
        .BYTES_PER_SAMPLE(BPS),
        .TIMEOUT_CLKS(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .grant(grant),
        .grant_valid(grant_valid),
        .abort(abort),
        .underrun(underrun),
        .samples_served(samples_served)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_on = 0;
    bit m_busy;
    int m_g;
    int m_reads;
    int m_quiet;
    bit m_ur;
    int m_last;
    int m_served;

    always @(posedge clk) begin
        if (rst) begin
            m_on     = 1;
            m_busy   = 0;
            m_g      = 0;
            m_reads  = 0;
            m_quiet  = 0;
            m_ur     = 0;
            m_last   = N - 1;
            m_served = 0;
        end else if (m_on) begin
            if (!m_busy) begin
                int start;
`ifdef PAM_ARB_FIXED_PRIO_EN
                start = 0;
`else
                start = m_last + 1;
`endif
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (start + k) % N;
                    if (!m_busy && !bus.req_empty[c]) begin
                        m_busy  = 1;
                        m_g     = c;
                        m_reads = 0;
                        m_quiet = 0;
                        m_ur    = 0;
                    end
                end
            end else if (m_reads == BPS) begin
                m_served = (m_served + 1) & 16'hFFFF;
                m_last   = m_g;
                m_busy   = 0;
            end else begin
                if (m_reads > 0 && bus.req_empty[m_g]) m_ur = 1;
                if (bus.mod_read) begin
                    m_reads++;
                    m_quiet = 0;
                end else if (m_quiet == T - 1) begin
                    m_busy = 0;
                    m_last = m_g;
                end else begin
                    m_quiet++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on && !rst) begin
            bit act;
            logic [7:0] e_ms;
            logic [1:0] e_rr;
            act  = m_busy && (m_reads < BPS);
            e_ms = m_busy ? bus.req_data[8*m_g +: 8] : 8'h00;
            e_rr = (act && bus.mod_read) ? 2'(1 << m_g) : 2'b00;
            chk("grant_valid", grant_valid, m_busy);
            chk("grant", grant, m_g);
            chk("mod_empty", bus.mod_empty,
                m_busy ? bus.req_empty[m_g] : 1'b1);
            chk("mod_sample", bus.mod_sample, e_ms);
            chk("req_read", bus.req_read, e_rr);
            chk("abort", abort,
                act && !bus.mod_read && (m_quiet == T - 1));
            chk("underrun", underrun,
                act && m_reads > 0 && bus.req_empty[m_g] && !m_ur);
            chk("samples_served", samples_served, m_served);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd();
        bus.mod_read = 1'b1;
        tick();
        bus.mod_read = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.mod_read  = 1'b0;
        bus.req_empty = 2'b11;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int seq[6];
    int exp_seq[6];
    int ab_at;
    int ur_cnt;
    bit seen;

    initial begin
        rst           = 1'b1;
        bus.mod_read  = 1'b0;
        bus.req_empty = 2'b11;
        bus.req_data  = 16'h3CA5;
        do_reset();

        // reset state
        #1;
        chk("rst_mod_empty", bus.mod_empty, 1'b1);
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_served", samples_served, 16'd0);
        chk("rst_grant", grant, 1'b0);

        // single requester
        bus.req_empty = 2'b10;
        tick();
        #1;
        chk("single_sample0", bus.mod_sample, 8'hA5);
        chk("single_empty", bus.mod_empty, 1'b0);
        bus.mod_read = 1'b1;
        #1;
        chk("single_rr0", bus.req_read, 2'b01);
        tick();
        bus.mod_read = 1'b0;
        bus.req_data = 16'h3C5A;
        #1;
        chk("single_sample1", bus.mod_sample, 8'h5A);
        rd();
        bus.req_empty = 2'b11;
        #1;
        chk("single_hold_gv", grant_valid, 1'b1);
        tick();
        #1;
        chk("single_gv_fall", grant_valid, 1'b0);
        chk("single_served", samples_served, 16'd1);

        // round-robin fairness
        do_reset();
        bus.req_empty = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick();
            seq[i] = int'(grant);
            rd();
            rd();
            tick();
        end
        bus.req_empty = 2'b11;
        for (int i = 0; i < 6; i++) begin
`ifdef PAM_ARB_FIXED_PRIO_EN
            exp_seq[i] = 0;
`else
            exp_seq[i] = i % 2;
`endif
            chk("rr_seq", seq[i], exp_seq[i]);
        end
        tick();
        chk("rr_served", samples_served, 16'd6);

        // grant lock
        do_reset();
        bus.req_empty = 2'b10;
        tick();
        rd();
        bus.req_empty = 2'b00;
        rd();
        #1;
        chk("lock_grant_hold", grant, 1'b0);
        tick();
        tick();
        #1;
        chk("lock_next_grant", grant, 1'b1);
        rd();
        rd();
        bus.req_empty = 2'b11;
        tick();

        // timeout
        do_reset();
        bus.req_empty = 2'b10;
        tick();
        bus.req_empty = 2'b00;
        ab_at = -1;
        seen  = 0;
        for (int c = 1; c <= T + 100; c++) begin
            #1;
            if (abort && !seen) begin
                ab_at = c;
                seen  = 1;
            end
            tick();
            if (seen) break;
        end
        chk("abort_cycle", ab_at, T);
        chk("abort_idle_gv", grant_valid, 1'b0);
        chk("abort_served", samples_served, 16'd0);
        tick();
        #1;
        chk("abort_next_grant", grant, 1'b1);
        rd();
        rd();
        bus.req_empty = 2'b11;
        tick();

        // underrun
        do_reset();
        bus.req_empty = 2'b10;
        tick();
        rd();
        bus.req_empty = 2'b11;
        ur_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (underrun) ur_cnt++;
            tick();
        end
        chk("underrun_pulses", ur_cnt, 1);
        rd();
        tick();
        #1;
        chk("underrun_served", samples_served, 16'd1);

        // reset mid-grant
        bus.req_empty = 2'b10;
        tick();
        rd();
        rst           = 1'b1;
        bus.req_empty = 2'b11;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_mod_empty", bus.mod_empty, 1'b1);
        chk("mrst_gv", grant_valid, 1'b0);
        chk("mrst_req_read", bus.req_read, 2'b00);
        chk("mrst_served", samples_served, 16'd0);
        chk("mrst_abort", abort, 1'b0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
